// File: rtl/i2c_arbiter.sv
// Round-robin arbiter that lets four requesters share one I2C master.
// It latches the winner's transaction fields, drives the start strobe and routes byte strobes back.
module i2c_arbiter #(
  parameter int unsigned ST_LEN = 10,
  parameter int unsigned TO_CYC = 50000
) (
  input  logic        clk_i,
  input  logic        rs_ni,
  input  logic [3:0]  req_i,
  input  logic [27:0] req_add_i,
  input  logic [3:0]  req_rw_i,
  input  logic [31:0] req_ct_i,
  input  logic [31:0] req_wd_i,
  input  logic        m_byte_done_i,
  input  logic        m_done_i,
  input  logic [7:0]  m_rd_i,
  output logic        st_o,
  output logic [6:0]  s_add_o,
  output logic        rw_o,
  output logic [7:0]  byte_ct_o,
  output logic [7:0]  wr_slave_o,
  output logic [3:0]  gnt_o,
  output logic [3:0]  ack_o,
  output logic [7:0]  rd_data_o,
  output logic [3:0]  rd_vld_o,
  output logic [3:0]  done_o,
  output logic [3:0]  err_o,
  output logic        m_abort_o
);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StCpl} state_e;

  state_e      state_q, state_d;
  logic [1:0]  last_q, last_d, win_q, win_d;
  logic [31:0] cnt_q, cnt_d;
  logic        st_q, st_d, rw_q, rw_d, abort_q, abort_d;
  logic [6:0]  s_add_q, s_add_d;
  logic [7:0]  ct_q, ct_d, wr_slave_q, wr_slave_d, rd_data_q, rd_data_d;
  logic [3:0]  gnt_q, gnt_d, ack_q, ack_d, rd_vld_q, rd_vld_d;
  logic [3:0]  done_q, done_d, err_q, err_d;

  logic [1:0]  pick, idx;
  logic        found;
  logic [3:0]  win_oh;
  logic        to_hit, st_end;

  // Search starts just after the last winner, so the previous winner ranks lowest.
  always_comb begin
    pick  = last_q;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && req_i[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign win_oh = 4'b0001 << win_q;
  assign to_hit = (cnt_q == TO_CYC - 1);
  assign st_end = (cnt_q == ST_LEN - 1);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    st_d       = st_q;
    s_add_d    = s_add_q;
    rw_d       = rw_q;
    ct_d       = ct_q;
    gnt_d      = gnt_q;
    rd_data_d  = rd_data_q;
    ack_d      = '0;
    rd_vld_d   = '0;
    done_d     = '0;
    err_d      = '0;
    abort_d    = 1'b0;
    wr_slave_d = (gnt_q != '0) ? req_wd_i[8*int'(win_q) +: 8] : wr_slave_q;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          win_d   = pick;
          gnt_d   = 4'b0001 << pick;
          s_add_d = req_add_i[7*int'(pick) +: 7];
          rw_d    = req_rw_i[pick];
          ct_d    = req_ct_i[8*int'(pick) +: 8];
          cnt_d   = '0;
          if (req_ct_i[8*int'(pick) +: 8] == 8'd0) begin
            // Empty transfer never touches the bus.
            done_d  = 4'b0001 << pick;
            last_d  = pick;
            state_d = StCpl;
          end else begin
            st_d    = 1'b1;
            state_d = StStart;
          end
        end
      end
      StStart: begin
        cnt_d = cnt_q + 32'd1;
        if (to_hit) begin
          st_d    = 1'b0;
          err_d   = win_oh;
          abort_d = 1'b1;
          last_d  = win_q;
          state_d = StCpl;
        end else if (st_end) begin
          st_d    = 1'b0;
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 32'd1;
        if (m_byte_done_i) begin
          ack_d = win_oh;
          if (rw_q) begin
            rd_data_d = m_rd_i;
            rd_vld_d  = win_oh;
          end
        end
        if (m_done_i) begin
          done_d  = win_oh;
          last_d  = win_q;
          state_d = StCpl;
        end else if (to_hit) begin
          err_d   = win_oh;
          abort_d = 1'b1;
          last_d  = win_q;
          state_d = StCpl;
        end
      end
      StCpl: begin
        gnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rs_ni) begin
    if (!rs_ni) begin
      state_q    <= StIdle;
      last_q     <= 2'd3;
      win_q      <= '0;
      cnt_q      <= '0;
      st_q       <= 1'b0;
      s_add_q    <= '0;
      rw_q       <= 1'b0;
      ct_q       <= '0;
      gnt_q      <= '0;
      wr_slave_q <= '0;
      rd_data_q  <= '0;
      ack_q      <= '0;
      rd_vld_q   <= '0;
      done_q     <= '0;
      err_q      <= '0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      st_q       <= st_d;
      s_add_q    <= s_add_d;
      rw_q       <= rw_d;
      ct_q       <= ct_d;
      gnt_q      <= gnt_d;
      wr_slave_q <= wr_slave_d;
      rd_data_q  <= rd_data_d;
      ack_q      <= ack_d;
      rd_vld_q   <= rd_vld_d;
      done_q     <= done_d;
      err_q      <= err_d;
      abort_q    <= abort_d;
    end
  end

  assign st_o       = st_q;
  assign s_add_o    = s_add_q;
  assign rw_o       = rw_q;
  assign byte_ct_o  = ct_q;
  assign wr_slave_o = wr_slave_q;
  assign gnt_o      = gnt_q;
  assign ack_o      = ack_q;
  assign rd_data_o  = rd_data_q;
  assign rd_vld_o   = rd_vld_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign m_abort_o  = abort_q;

endmodule
